mode_stack: RTL and testbench

MODE_STACK -- requirements
Module: mode_stack

---
 rtl/mode_stack_pkg.sv | 14 +
 rtl/mode_stack_mem.sv | 28 ++
 rtl/mode_stack.sv | 139 +++++++++++++
 tb/tb_mode_stack.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mode_stack_pkg.sv
// Shared types and helpers for the mode_stack LIFO/FIFO buffer.
// Optional error flags: build with MODE_STACK_ERR_FLAGS_EN.
package mode_stack_pkg;

    typedef enum logic {
        MODE_LIFO = 1'b0,
        MODE_FIFO = 1'b1
    } mode_e;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mode_stack_mem.sv
// Storage array for mode_stack: one synchronous write port,
// one asynchronous read port.
module mode_stack_mem
    import mode_stack_pkg::*;
#(
    parameter int BANDWIDTH = 4,
    parameter int DEPTH     = 8,
    parameter int AW        = ptr_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [BANDWIDTH-1:0] wdata,
    input  logic [AW-1:0]        raddr,
    output logic [BANDWIDTH-1:0] rdata
);

    logic [BANDWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mode_stack.sv
// Buffer switchable between LIFO and FIFO order while empty.
// Optional sticky overflow/underflow outputs: MODE_STACK_ERR_FLAGS_EN.
module mode_stack
    import mode_stack_pkg::*;
#(
    parameter int BANDWIDTH = 4,
    parameter int DEPTH     = 8,
    parameter int AF_LEVEL  = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       mode,
    input  logic                       push,
    input  logic                       pop,
    input  logic [BANDWIDTH-1:0]       data_in,
    output logic [BANDWIDTH-1:0]       data_out,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full
`ifdef MODE_STACK_ERR_FLAGS_EN
    ,
    output logic                       overflow,
    output logic                       underflow
`endif
);

    localparam int AW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

    mode_e                mode_q;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW-1:0]        top_idx;
    logic [AW-1:0]        waddr;
    logic [AW-1:0]        raddr;
    logic [BANDWIDTH-1:0] rdata;
    logic [CW-1:0]        count_d;
    logic                 is_fifo;
    logic                 pop_ok;
    logic                 push_ok;
    logic                 bypass;
    logic                 mem_we;
    logic                 inc;
    logic                 dec;

    assign empty       = (count == '0);
    assign full        = (count == DEPTH_C);
    assign almost_full = (count >= AF_C);

    assign is_fifo = (mode_q == MODE_FIFO);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    // LIFO push+pop on empty hands data_in straight through
    assign bypass  = !is_fifo && empty && push && pop;
    assign mem_we  = push_ok && !bypass;

    // count==DEPTH wraps to 0 here, so top_idx is DEPTH-1 when full
    assign top_idx = count[AW-1:0] - AW'(1);

    always_comb begin
        waddr = wr_ptr;
        raddr = rd_ptr;
        if (!is_fifo) begin
            raddr = top_idx;
            waddr = pop_ok ? top_idx : count[AW-1:0];
        end
    end

    assign inc = mem_we && !pop_ok;
    assign dec = pop_ok && !push_ok;

    always_comb begin
        count_d = count;
        unique case (1'b1)
            inc:     count_d = count + CW'(1);
            dec:     count_d = count - CW'(1);
            default: count_d = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            data_out <= '0;
            mode_q   <= MODE_LIFO;
        end else begin
            count <= count_d;
            if (is_fifo && mem_we) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (is_fifo && pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (bypass) begin
                data_out <= data_in;
            end else if (pop_ok) begin
                data_out <= rdata;
            end
            if (empty && !push_ok) begin
                mode_q <= mode_e'(mode);
            end
        end
    end

`ifdef MODE_STACK_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rstn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && full && !pop_ok) begin
                overflow <= 1'b1;
            end
            if (pop && empty && !bypass) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

    mode_stack_mem #(
        .BANDWIDTH (BANDWIDTH),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (waddr),
        .wdata (data_in),
        .raddr (raddr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_mode_stack.sv
// Scoreboard bench for mode_stack (DEPTH=8, BANDWIDTH=4, AF_LEVEL=7).
// Error-flag checks follow MODE_STACK_ERR_FLAGS_EN.
module tb_mode_stack;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       mode = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [3:0] data_in = 4'd0;
    logic [3:0] data_out;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
`ifdef MODE_STACK_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    typedef struct {
        logic [3:0] dout;
        int         cnt;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    logic exp_ovf = 1'b0;
    logic exp_unf = 1'b0;

    always #5 clk = ~clk;

    mode_stack #(
        .BANDWIDTH (4),
        .DEPTH     (8),
        .AF_LEVEL  (7)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .mode        (mode),
        .push        (push),
        .pop         (pop),
        .data_in     (data_in),
        .data_out    (data_out),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full)
`ifdef MODE_STACK_ERR_FLAGS_EN
        ,
        .overflow    (overflow),
        .underflow   (underflow)
`endif
    );

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic step(input logic rs, input logic md, input logic ps,
                        input logic pp, input logic [3:0] din,
                        input logic [3:0] edout, input int ecnt);
        exp_t e;
        @(negedge clk);
        rstn    = rs;
        mode    = md;
        push    = ps;
        pop     = pp;
        data_in = din;
        e.dout  = edout;
        e.cnt   = ecnt;
        e.ovf   = exp_ovf;
        e.unf   = exp_unf;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("data_out", int'(data_out), int'(e.dout));
                chk("count", int'(count), e.cnt);
                chk("empty", int'(empty), int'(e.cnt == 0));
                chk("full", int'(full), int'(e.cnt == 8));
                chk("almost_full", int'(almost_full), int'(e.cnt >= 7));
`ifdef MODE_STACK_ERR_FLAGS_EN
                chk("overflow", int'(overflow), int'(e.ovf));
                chk("underflow", int'(underflow), int'(e.unf));
`endif
            end
        end
    end

    initial begin : stim
        step(1, 0, 0, 0, 4'd0, 4'd0, 0);
        step(1, 0, 1, 1, 4'd3, 4'd0, 0);

        // LIFO bypass on empty
        step(0, 0, 1, 1, 4'd5, 4'd5, 0);

        // LIFO fill and overflow
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 1, 0, 4'(i), 4'd5, i);
        end
        exp_ovf = 1'b1;
        step(0, 0, 1, 0, 4'd9, 4'd5, 8);

        // LIFO drain and underflow
        for (int i = 8; i >= 1; i--) begin
            step(0, 0, 0, 1, 4'd0, 4'(i), i - 1);
        end
        exp_unf = 1'b1;
        step(0, 0, 0, 1, 4'd0, 4'd1, 0);

        // mode change while non-empty is ignored
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 1, 0, 4'(i), 4'd1, i);
        end
        step(0, 1, 1, 0, 4'd4, 4'd1, 4);
        step(0, 1, 0, 1, 4'd0, 4'd4, 3);
        step(0, 1, 0, 1, 4'd0, 4'd3, 2);
        step(0, 1, 1, 1, 4'd9, 4'd2, 2);
        step(0, 0, 0, 1, 4'd0, 4'd9, 1);
        for (int i = 2; i <= 5; i++) begin
            step(0, 0, 1, 0, 4'(i), 4'd9, i);
        end

        // reset mid-operation
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        step(1, 0, 1, 0, 4'd7, 4'd0, 0);

        // switch to FIFO, then push+pop on empty
        step(0, 1, 0, 0, 4'd0, 4'd0, 0);
        exp_unf = 1'b1;
        step(0, 1, 1, 1, 4'd3, 4'd0, 1);
        step(0, 1, 0, 1, 4'd0, 4'd3, 0);

        // FIFO wrap
        for (int i = 1; i <= 5; i++) begin
            step(0, 1, 1, 0, 4'(i), 4'd3, i);
        end
        for (int i = 1; i <= 3; i++) begin
            step(0, 1, 0, 1, 4'd0, 4'(i), 5 - i);
        end
        for (int i = 6; i <= 11; i++) begin
            step(0, 1, 1, 0, 4'(i), 4'd3, i - 3);
        end
        for (int i = 4; i <= 11; i++) begin
            step(0, 1, 0, 1, 4'd0, 4'(i), 11 - i);
        end

        // FIFO push+pop while full
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 1, 0, 4'(i), 4'd11, i);
        end
        step(0, 1, 1, 1, 4'd12, 4'd1, 8);
        step(0, 1, 0, 1, 4'd0, 4'd2, 7);

        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        step(1, 1, 0, 1, 4'd0, 4'd0, 0);
        step(0, 0, 0, 0, 4'd0, 4'd0, 0);

        @(negedge clk);
        rstn = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
